// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd3;
  localparam logic [3:0] ALU_ORZ = 4'd5;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_REG = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_DM  = 2'd1;
  localparam logic [1:0] SRC_PC4 = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_J, CL_JAL, CL_JR, CL_BEQ, CL_ALU, CL_LW, CL_SW
  } cls_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct decode into class, selects and illegal flag
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [1:0] npc,
  output logic [1:0] reg_dst,
  output logic [1:0] reg_src,
  output logic [3:0] alu_ctr,
  output logic       alu_src,
  output logic       imm_src,
  output logic       illegal
);

  always_comb begin
    cls     = CL_NOP;
    npc     = NPC_PC4;
    reg_dst = DST_RT;
    reg_src = SRC_ALU;
    alu_ctr = ALU_ADD;
    alu_src = 1'b0;
    imm_src = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin cls = CL_ALU; reg_dst = DST_RD; alu_ctr = ALU_ADD; end
          FN_SUBU: begin cls = CL_ALU; reg_dst = DST_RD; alu_ctr = ALU_SUB; end
          FN_JR:   begin cls = CL_JR;  npc = NPC_REG; imm_src = 1'b1; end
          FN_NOP:  cls = CL_NOP;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI:  begin cls = CL_ALU; alu_ctr = ALU_ORZ; alu_src = 1'b1; end
      OP_LUI:  begin cls = CL_ALU; alu_ctr = ALU_LUI; alu_src = 1'b1; end
      OP_LW:   begin cls = CL_LW; alu_ctr = ALU_ADD; alu_src = 1'b1; reg_src = SRC_DM; end
      OP_SW:   begin cls = CL_SW; alu_ctr = ALU_ADD; alu_src = 1'b1; end
      // beq target vs fall-through depends on eq, resolved by the sequencer
      OP_BEQ:  cls = CL_BEQ;
      OP_J:    begin cls = CL_J; npc = NPC_J; end
      OP_JAL:  begin cls = CL_JAL; npc = NPC_J; reg_dst = DST_RA; reg_src = SRC_PC4; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait,
// illegal-instruction trap and retired-instruction counter
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        eq,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  NPC,
  output logic [1:0]  RegDst,
  output logic [1:0]  RegSrc,
  output logic [3:0]  ALUCtr,
  output logic        ALUSrc,
  output logic        ImmSrc,
  output logic        illegal,
  output logic [2:0]  state_o,
  output logic [31:0] retired
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        illegal_q;
  logic [31:0] retired_q;

  cls_t        d_cls;
  logic [1:0]  d_npc, d_reg_dst, d_reg_src;
  logic [3:0]  d_alu_ctr;
  logic        d_alu_src, d_imm_src, d_illegal;

  logic        pc_we, ir_we, rf_we, dm_we;
  logic        mem_done, is_short, sel_on;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (d_cls),
    .npc     (d_npc),
    .reg_dst (d_reg_dst),
    .reg_src (d_reg_src),
    .alu_ctr (d_alu_ctr),
    .alu_src (d_alu_src),
    .imm_src (d_imm_src),
    .illegal (d_illegal)
  );

  assign mem_done = (wait_cnt == WAIT_LAST);
  assign is_short = (d_cls == CL_NOP) || (d_cls == CL_J) || (d_cls == CL_JAL) ||
                    (d_cls == CL_JR)  || (d_cls == CL_BEQ);

  always_comb begin
    pc_we = 1'b0;
    ir_we = 1'b0;
    rf_we = 1'b0;
    dm_we = 1'b0;
    case (state)
      ST_FETCH:  ir_we = 1'b1;
      ST_DECODE: begin
        if (!d_illegal && is_short) begin
          pc_we = 1'b1;
          rf_we = (d_cls == CL_JAL);
        end
      end
      ST_MEM: begin
        if (mem_done && d_cls == CL_SW) begin
          dm_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      ST_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // enables are masked by reset directly so an abort can never leak a write
  assign PCWrite  = pc_we & rst;
  assign IRWrite  = ir_we & rst;
  assign RegWrite = rf_we & rst;
  assign MemWrite = dm_we & rst;

  assign sel_on  = (state != ST_FETCH);
  assign NPC     = !sel_on ? NPC_PC4 : ((d_cls == CL_BEQ && eq) ? NPC_BR : d_npc);
  assign RegDst  = sel_on ? d_reg_dst : DST_RT;
  assign RegSrc  = sel_on ? d_reg_src : SRC_ALU;
  assign ALUCtr  = sel_on ? d_alu_ctr : ALU_ADD;
  assign ALUSrc  = sel_on & d_alu_src;
  assign ImmSrc  = sel_on & d_imm_src;

  assign illegal = illegal_q;
  assign state_o = state;
  assign retired = retired_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH;
      wait_cnt  <= 4'd0;
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      if (pc_we) retired_q <= retired_q + 32'd1;
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (d_illegal) begin
            state     <= ST_ERR;
            illegal_q <= 1'b1;
          end else if (is_short) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wait_cnt <= 4'd0;
          state    <= (d_cls == CL_LW || d_cls == CL_SW) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (mem_done) state <= (d_cls == CL_SW) ? ST_FETCH : ST_WB;
          else          wait_cnt <= wait_cnt + 4'd1;
        end
        ST_WB:   state <= ST_FETCH;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [5:0]  opcode, funct;
  logic        eq;

  logic        PCWrite, IRWrite, RegWrite, MemWrite, ALUSrc, ImmSrc, illegal;
  logic [1:0]  NPC, RegDst, RegSrc;
  logic [3:0]  ALUCtr;
  logic [2:0]  state_o;
  logic [31:0] retired;

  logic        PCWrite2, IRWrite2, RegWrite2, MemWrite2, ALUSrc2, ImmSrc2, illegal2;
  logic [1:0]  NPC2, RegDst2, RegSrc2;
  logic [3:0]  ALUCtr2;
  logic [2:0]  state2;
  logic [31:0] retired2;

  int n_checks = 0;
  int n_fail   = 0;

  int          r_cyc, r_pcw, r_rfw, r_dmw, r_irw;
  logic [31:0] r_trace;
  logic [11:0] r_fetch_sel;
  logic [1:0]  s_npc, s_dst, s_src;
  logic [3:0]  s_alu;
  logic        s_asrc, s_imm, s_rw, s_mw;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_WAIT(2)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .eq(eq),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .NPC(NPC), .RegDst(RegDst), .RegSrc(RegSrc), .ALUCtr(ALUCtr), .ALUSrc(ALUSrc),
    .ImmSrc(ImmSrc), .illegal(illegal), .state_o(state_o), .retired(retired)
  );

  mc_ctrl #(.MEM_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst2), .opcode(opcode), .funct(funct), .eq(eq),
    .PCWrite(PCWrite2), .IRWrite(IRWrite2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
    .NPC(NPC2), .RegDst(RegDst2), .RegSrc(RegSrc2), .ALUCtr(ALUCtr2), .ALUSrc(ALUSrc2),
    .ImmSrc(ImmSrc2), .illegal(illegal2), .state_o(state2), .retired(retired2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // run one instruction from FETCH until its PCWrite cycle, recording trace and pulses
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic e);
    bit done = 0;
    opcode = op; funct = fn; eq = e;
    r_cyc = 0; r_trace = 0; r_pcw = 0; r_rfw = 0; r_dmw = 0; r_irw = 0;
    r_fetch_sel = {NPC, RegDst, RegSrc, ALUCtr, ALUSrc, ImmSrc};
    while (!done && r_cyc < 20) begin
      r_cyc++;
      r_trace = {r_trace[27:0], 1'b0, state_o};
      r_pcw += int'(PCWrite); r_rfw += int'(RegWrite);
      r_dmw += int'(MemWrite); r_irw += int'(IRWrite);
      if (PCWrite) begin
        {s_npc, s_dst, s_src, s_alu, s_asrc, s_imm} = {NPC, RegDst, RegSrc, ALUCtr, ALUSrc, ImmSrc};
        s_rw = RegWrite; s_mw = MemWrite;
        done = 1;
      end
      step();
    end
    check("instr_done", 32'(done), 32'd1);
  endtask

  task automatic expect_instr(input string tag, input int cyc, input logic [31:0] trace,
                              input logic [1:0] npc, input logic [1:0] dst, input logic [1:0] src,
                              input logic [3:0] alu, input logic asrc, input logic imm,
                              input logic rw, input logic mw);
    check({tag, ".cycles"}, 32'(r_cyc), 32'(cyc));
    check({tag, ".trace"}, r_trace, trace);
    check({tag, ".sel"}, 32'({s_npc, s_dst, s_src, s_alu, s_asrc, s_imm}),
          32'({npc, dst, src, alu, asrc, imm}));
    check({tag, ".we_last"}, 32'({s_rw, s_mw}), 32'({rw, mw}));
    check({tag, ".pulses"}, 32'({r_pcw[3:0], r_irw[3:0], r_rfw[3:0], r_dmw[3:0]}),
          32'({4'd1, 4'd1, 3'd0, rw, 3'd0, mw}));
    check({tag, ".fetch_sel"}, 32'(r_fetch_sel), 32'd0);
    check({tag, ".next_state"}, 32'(state_o), 32'd0);
  endtask

  task automatic run_illegal(input string tag, input logic [5:0] op, input logic [5:0] fn);
    int en_cnt = 0;
    opcode = op; funct = fn; eq = 1'b0;
    check({tag, ".start"}, 32'(state_o), 32'd0);
    step();
    check({tag, ".decode_en"}, 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    step();
    check({tag, ".err_state"}, 32'(state_o), 32'd5);
    check({tag, ".flag"}, 32'(illegal), 32'd1);
    for (int i = 0; i < 10; i++) begin
      en_cnt += int'(PCWrite) + int'(IRWrite) + int'(RegWrite) + int'(MemWrite);
      step();
    end
    check({tag, ".hold_en"}, 32'(en_cnt), 32'd0);
    check({tag, ".hold_state"}, 32'(state_o), 32'd5);
    rst = 1'b0;
    #1;
    check({tag, ".rst_clear"}, 32'({illegal, state_o}), 32'd0);
    check({tag, ".rst_retired"}, retired, 32'd0);
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int mw2 = 0;
    rst = 1'b0; rst2 = 1'b0; opcode = 6'h00; funct = 6'h00; eq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    check("rst.state", 32'(state_o), 32'd0);
    check("rst.retired", retired, 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    rst = 1'b1;
    #1;
    check("rel.irwrite", 32'(IRWrite), 32'd1);

    //                                     cyc trace        npc dst src alu asrc imm rw mw
    run_instr(6'h00, 6'h21, 1'b0); expect_instr("addu", 4, 32'h0124,    0, 1, 0, 0, 0, 0, 1, 0);
    check("addu.retired", retired, 32'd1);
    run_instr(6'h00, 6'h23, 1'b0); expect_instr("subu", 4, 32'h0124,    0, 1, 0, 1, 0, 0, 1, 0);
    run_instr(6'h0D, 6'h00, 1'b0); expect_instr("ori",  4, 32'h0124,    0, 0, 0, 5, 1, 0, 1, 0);
    run_instr(6'h0F, 6'h00, 1'b0); expect_instr("lui",  4, 32'h0124,    0, 0, 0, 3, 1, 0, 1, 0);
    run_instr(6'h23, 6'h00, 1'b0); expect_instr("lw",   7, 32'h0123334, 0, 0, 1, 0, 1, 0, 1, 0);
    run_instr(6'h2B, 6'h00, 1'b0); expect_instr("sw",   6, 32'h012333,  0, 0, 0, 0, 1, 0, 0, 1);
    run_instr(6'h04, 6'h00, 1'b1); expect_instr("beq1", 2, 32'h01,      1, 0, 0, 0, 0, 0, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0); expect_instr("beq0", 2, 32'h01,      0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(6'h02, 6'h00, 1'b0); expect_instr("j",    2, 32'h01,      2, 0, 0, 0, 0, 0, 0, 0);
    run_instr(6'h03, 6'h00, 1'b0); expect_instr("jal",  2, 32'h01,      2, 2, 2, 0, 0, 0, 1, 0);
    run_instr(6'h00, 6'h08, 1'b0); expect_instr("jr",   2, 32'h01,      3, 0, 0, 0, 0, 1, 0, 0);
    run_instr(6'h00, 6'h00, 1'b0); expect_instr("nop",  2, 32'h01,      0, 0, 0, 0, 0, 0, 0, 0);
    check("all.retired", retired, 32'd12);

    run_illegal("ill_op", 6'h3F, 6'h00);
    run_illegal("ill_fn", 6'h00, 6'h3F);

    rst = 1'b0;
    opcode = 6'h2B; funct = 6'h00;
    rst2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mw2 += int'(MemWrite2);
      step();
    end
    check("abort.in_mem", 32'(state2), 32'd3);
    rst2 = 1'b0;
    #1;
    check("abort.state", 32'(state2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      mw2 += int'(MemWrite2) + int'(PCWrite2) + int'(RegWrite2);
      step();
    end
    check("abort.no_write", 32'(mw2), 32'd0);
    rst2 = 1'b1;
    #1;
    check("abort.refetch", 32'({state2, IRWrite2}), 32'({3'd0, 1'b1}));
    check("abort.retired", retired2, 32'd0);
    rst2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS datapath. It decodes the latched instruction's `opcode`/`funct` and steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. In each state it drives the datapath's control inputs and its PC/IR/register/memory write enables. It replaces the single-cycle combinational controller and adds a configurable memory wait, an illegal-instruction trap and a retired-instruction counter.

## Interface
- `MEM_WAIT`, default 0: extra stall cycles spent in MEM before the access completes (0..15).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instr[31:26] from the IR.
- `funct`  in  6  instr[5:0] from the IR.
- `eq`  in  1  datapath comparator, 1 when GRF rs == rt.
- `PCWrite`  out  1  PC update enable.
- `IRWrite`  out  1  IR load enable.
- `RegWrite`  out  1  GRF write enable.
- `MemWrite`  out  1  DM store enable.
- `NPC`  out  2  next-PC select: 0 PC+4, 1 branch (PC+4+sext(imm)<<2), 2 jump imm26, 3 register target.
- `RegDst`  out  2  write register: 0 rt, 1 rd, 2 $31.
- `RegSrc`  out  2  write data: 0 ALU, 1 DM, 2 PC+4.
- `ALUCtr`  out  4  ALU op: 0 ADD, 1 SUB, 2 OR, 3 LUI (B[15:0]<<16), 5 ORZ (A | zext(B[15:0])).
- `ALUSrc`  out  1  ALU B: 0 rt data, 1 sign-extended imm.
- `ImmSrc`  out  1  IFU imm32 source: 0 sext imm, 1 register data (jr).
- `illegal`  out  1  sticky, set on an undecodable instruction.
- `state_o`  out  3  current state, for debug.
- `retired`  out  32  count of completed instructions.

## Operation
- Supported instructions: addu (R, funct 0x21), subu (0x23), jr (0x08), nop (R, funct 0x00), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03. Anything else is illegal.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, ERR 5.
- The PC is stable for the whole instruction. `PCWrite` pulses only in the instruction's final cycle, so PC+4 and branch targets are always computed from the current PC.
- FETCH: `IRWrite`=1, then go to DECODE.
- DECODE:
  - illegal → ERR.
  - nop → `PCWrite`, `NPC`=0.
  - j → `PCWrite`, `NPC`=2.
  - jal → `PCWrite`, `NPC`=2, `RegWrite`, `RegDst`=2, `RegSrc`=2.
  - jr → `PCWrite`, `NPC`=3, `ImmSrc`=1.
  - beq → `PCWrite`, `NPC`=1 if `eq` else 0.
  - These all go to FETCH; every other instruction goes to EXEC.
- EXEC: ALU controls only, no enables. addu/subu/ori/lui → WB; lw/sw → MEM.
- MEM: a wait counter is cleared on entry and counts up to `MEM_WAIT`. On the final MEM cycle:
  - sw: `MemWrite`=1 and `PCWrite`=1 (`NPC`=0), then go to FETCH.
  - lw: go to WB.
- WB: `RegWrite`=1 and `PCWrite`=1 (`NPC`=0), then go to FETCH.
  - `RegDst`: 1 for addu/subu, 0 otherwise.
  - `RegSrc`: 1 for lw, 0 otherwise.
- ERR: all enables 0; hold until reset; `illegal`=1.
- Mux/ALU selects decode from `opcode`/`funct` in every state except FETCH, where they are 0.
  - `ALUCtr`: addu ADD, subu SUB, ori ORZ, lui LUI, lw/sw ADD.
  - `ALUSrc`: 1 for ori, lui, lw and sw.
- `retired` increments, wrapping mod 2^32, on every cycle where `PCWrite`=1.

## Timing
- Reset (`rst` low, asynchronous):
  - state = FETCH, wait counter = 0, `illegal` = 0, `retired` = 0.
  - All write enables are forced to 0 while `rst` is low, combinationally.
  - On the first rising edge after release, FETCH is active with `IRWrite`=1.
- Latency in cycles:
  - nop, j, jal, jr, beq: 2.
  - addu, subu, ori, lui: 4.
  - sw: 4+`MEM_WAIT`.
  - lw: 5+`MEM_WAIT`.
- Each enable is a single-cycle pulse per instruction; there are never two `PCWrite` pulses in one instruction.
- `eq` is sampled only in DECODE.
- Reset asserted mid-instruction aborts the instruction. No partial write may be issued after the reset edge.
- `opcode`/`funct` are assumed stable from the DECODE cycle to the end of the instruction, because the IR is only written in FETCH.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct constants;
  - `ALUCtr`, `NPC`, `RegDst` and `RegSrc` code constants;
  - the state enum.
- Sub-module `mc_decode`: purely combinational. It maps `opcode`/`funct` to an instruction class plus the mux/ALU select values and an illegal flag.
- `mc_ctrl` owns the state register, wait counter, sticky flag, retired counter and the state-dependent enable gating.

## Test plan
- Reset: hold `rst` low for 3 cycles → all enables 0, `state_o`=0, `retired`=0. After release, `IRWrite`=1 on the first cycle.
- addu (op 0, funct 0x21) → state sequence 0,1,2,4,0. In state 4: `RegWrite`=1, `RegDst`=1, `RegSrc`=0, `ALUCtr`=0, `PCWrite`=1. `retired`=1.
- lw (0x23), `MEM_WAIT`=2 → 3 MEM cycles, then WB with `RegSrc`=1, `RegDst`=0, `ALUSrc`=1. Total 7 cycles. sw (0x2B): `MemWrite` pulses exactly once, on the last MEM cycle.
- beq (0x04): with `eq`=1 → `NPC`=1 in DECODE; with `eq`=0 → `NPC`=0. Both take 2 cycles. jal (0x03) → `RegDst`=2, `RegSrc`=2, `NPC`=2, `RegWrite`=1.
- Illegal opcode 0x3F → ERR, `illegal`=1, no enables for 10 cycles. `rst` low clears it.
- Assert `rst` during MEM of sw with `MEM_WAIT`=3 → `MemWrite` never pulses, and the state returns to FETCH.
